// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared definitions for the load/store data path.
//   mem_size_e   - access size encoding carried on size_i (11 is reserved).
//   BYTE_LANES   - byte lanes per 32-bit word.
//   byte_enable  - byte-lane write mask for a given size and lane.
//   misaligned   - access cannot be served at this lane (or size is reserved).
package riscv_mem_pkg;

    localparam int unsigned BYTE_LANES = 4;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } mem_size_e;

    function automatic logic [BYTE_LANES-1:0] byte_enable(mem_size_e size, logic [1:0] lane);
        logic [BYTE_LANES-1:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << lane;
            SIZE_HALF: be = 4'b0011 << lane;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic misaligned(mem_size_e size, logic [1:0] lane);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = lane[0];
            SIZE_WORD: bad = (lane != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/riscv_load_align.sv
// riscv_load_align: combinational lane extract and sign/zero extension of a loaded word.
// Ports:
//   word_i     - full 32-bit word as read from storage
//   lane_i     - byte lane of the access (address bits [1:0])
//   size_i     - access size (mem_size_e encoding)
//   unsigned_i - 1 = zero-extend, 0 = sign-extend
//   data_o     - right-justified, extended load data (0 for the reserved size)
module riscv_load_align
    import riscv_mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;
    logic        sign_b;
    logic        sign_h;

    // Move the addressed lane down to bit 0 so every size extracts from the bottom.
    assign shifted = word_i >> {lane_i, 3'b000};
    assign sign_b  = ~unsigned_i & shifted[7];
    assign sign_h  = ~unsigned_i & shifted[15];

    always_comb begin
        data_o = '0;
        case (mem_size_e'(size_i))
            SIZE_BYTE: data_o = {{24{sign_b}}, shifted[7:0]};
            SIZE_HALF: data_o = {{16{sign_h}}, shifted[15:0]};
            SIZE_WORD: data_o = shifted;
            default:   data_o = '0;
        endcase
    end

endmodule

// File: rtl/riscv_data_ram.sv
// riscv_data_ram: single-port byte-addressed data memory for the load/store unit.
// Byte/half/word accesses, byte-lane writes, sign/zero-extended loads, error reporting
// for misaligned, reserved-size and out-of-range requests. One request per cycle.
// Ports:
//   clk_clk_i  - clock
//   rst_rst_i  - synchronous active-high reset (memory contents are not reset)
//   req_i      - access request
//   we_i       - 1 = store, 0 = load
//   size_i     - 00 byte, 01 half, 10 word, 11 reserved (error)
//   unsigned_i - load zero-extend (1) / sign-extend (0)
//   addr_i     - byte address
//   wdata_i    - right-justified store data
//   rdata_o    - extended load data, updated only by error-free loads
//   rvalid_o   - one-cycle response pulse for each accepted request
//   err_o      - response carries an error (qualified by rvalid_o)
// Optional build macro RISCV_DRAM_OUTREG_EN: extra output register stage (latency 2).
module riscv_data_ram
    import riscv_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned RAM_DEPTH  = 1 << (ADDR_WIDTH - 2)
) (
    input  logic                  clk_clk_i,
    input  logic                  rst_rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o,
    output logic                  err_o
);

    localparam int unsigned IdxW    = ADDR_WIDTH - 2;
    localparam int unsigned MemIdxW = $clog2(RAM_DEPTH);
    localparam logic [IdxW:0] DepthLim = RAM_DEPTH[IdxW:0];

    // Request decode
    mem_size_e              size;
    logic [1:0]             lane;
    logic [IdxW-1:0]        word_idx;
    logic [MemIdxW-1:0]     mem_idx;
    logic                   out_of_range;
    logic                   req_err;
    logic                   do_store;
    logic                   do_load;
    logic [BYTE_LANES-1:0]  be;
    logic [DATA_WIDTH-1:0]  wdata_rep;

    assign size         = mem_size_e'(size_i);
    assign lane         = addr_i[1:0];
    assign word_idx     = addr_i[ADDR_WIDTH-1:2];
    assign mem_idx      = word_idx[MemIdxW-1:0];
    assign out_of_range = ({1'b0, word_idx} >= DepthLim);
    assign req_err      = misaligned(size, lane) | out_of_range;
    assign do_store     = req_i & we_i & ~req_err;
    assign do_load      = req_i & ~we_i & ~req_err;
    assign be           = byte_enable(size, lane);

    // Replicate store data into every lane; the byte enables pick the lane(s) that land.
    always_comb begin
        wdata_rep = wdata_i;
        case (size)
            SIZE_BYTE: wdata_rep = {4{wdata_i[7:0]}};
            SIZE_HALF: wdata_rep = {2{wdata_i[15:0]}};
            default:   wdata_rep = wdata_i;
        endcase
    end

    // Storage
    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

    always_ff @(posedge clk_clk_i) begin
        if (!rst_rst_i && do_store) begin
            for (int b = 0; b < BYTE_LANES; b++) begin
                if (be[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                end
            end
        end
    end

    // Load datapath: full word plus lane/size/sign captured in the request cycle.
    logic [DATA_WIDTH-1:0] rword_q;
    logic [1:0]            lane_q;
    logic [1:0]            size_q;
    logic                  uns_q;

    always_ff @(posedge clk_clk_i) begin
        if (do_load) begin
            rword_q <= mem_q[mem_idx];
            lane_q  <= lane;
            size_q  <= size_i;
            uns_q   <= unsigned_i;
        end
    end

    logic [DATA_WIDTH-1:0] aligned;

    riscv_load_align u_load_align (
        .word_i     (rword_q),
        .lane_i     (lane_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (aligned)
    );

    // Response stage
    logic                  rvalid_q;
    logic                  err_q;
    logic                  load_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    // rdata only moves on an error-free load response; everything else holds it.
    assign rdata_d = load_q ? aligned : rdata_q;

    always_ff @(posedge clk_clk_i) begin
        if (rst_rst_i) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            load_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= req_i;
            err_q    <= req_i & req_err;
            load_q   <= do_load;
            rdata_q  <= rdata_d;
        end
    end

`ifdef RISCV_DRAM_OUTREG_EN
    logic                  rvalid2_q;
    logic                  err2_q;
    logic [DATA_WIDTH-1:0] rdata2_q;

    always_ff @(posedge clk_clk_i) begin
        if (rst_rst_i) begin
            rvalid2_q <= 1'b0;
            err2_q    <= 1'b0;
            rdata2_q  <= '0;
        end else begin
            rvalid2_q <= rvalid_q;
            err2_q    <= err_q;
            rdata2_q  <= rdata_d;
        end
    end

    assign rvalid_o = rvalid2_q;
    assign err_o    = err2_q;
    assign rdata_o  = rdata2_q;
`else
    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_d;
`endif

endmodule

// File: tb/tb_riscv_data_ram.sv
// Directed bench for riscv_data_ram: expected responses are queued with their due cycle
// when a request is driven and checked by a negedge monitor when that cycle arrives.
module tb_riscv_data_ram;
    import riscv_mem_pkg::*;

`ifdef RISCV_DRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [9:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;

    riscv_data_ram #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (10),
        .RAM_DEPTH  (64)
    ) dut (
        .clk_clk_i  (clk),
        .rst_rst_i  (rst),
        .req_i      (req),
        .we_i       (we),
        .size_i     (size),
        .unsigned_i (uns),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .rdata_o    (rdata),
        .rvalid_o   (rvalid),
        .err_o      (err)
    );

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [31:0] last_rdata = '0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Response monitor: a response is due exactly at the recorded cycle, otherwise idle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check("rvalid", {31'b0, rvalid}, 32'd1);
            check("err", {31'b0, err}, {31'b0, e.err});
            check("rdata", rdata, e.data);
        end else begin
            check("idle_rvalid", {31'b0, rvalid}, 32'd0);
        end
    end

    // One request for one cycle; called at posedge+1.
    task automatic access(input logic w, input logic [1:0] sz, input logic u,
                          input logic [9:0] a, input logic [31:0] d,
                          input logic e_err, input logic [31:0] e_data);
        exp_t e;
        req   = 1'b1;
        we    = w;
        size  = sz;
        uns   = u;
        addr  = a;
        wdata = d;
        if (!w && !e_err) last_rdata = e_data;
        e.due  = cyc + LAT;
        e.err  = e_err;
        e.data = last_rdata;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        we  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdata", rdata, 32'h0);
        check("reset_err", {31'b0, err}, 32'd0);
        rst = 1'b0;
        idle(1);

        // Word store then load
        access(1'b1, SIZE_WORD, 1'b0, 10'h010, 32'hDEADBEEF, 1'b0, 32'h0);
        access(1'b0, SIZE_WORD, 1'b0, 10'h010, 32'h0, 1'b0, 32'hDEADBEEF);
        // Byte store, signed byte load, word load
        access(1'b1, SIZE_BYTE, 1'b0, 10'h011, 32'h0000005A, 1'b0, 32'h0);
        access(1'b0, SIZE_BYTE, 1'b0, 10'h013, 32'h0, 1'b0, 32'hFFFFFFDE);
        access(1'b0, SIZE_WORD, 1'b0, 10'h010, 32'h0, 1'b0, 32'hDEAD5AEF);
        access(1'b0, SIZE_BYTE, 1'b1, 10'h011, 32'h0, 1'b0, 32'h0000005A);
        // Half loads and misaligned half
        access(1'b0, SIZE_HALF, 1'b1, 10'h012, 32'h0, 1'b0, 32'h0000DEAD);
        access(1'b0, SIZE_HALF, 1'b0, 10'h012, 32'h0, 1'b0, 32'hFFFFDEAD);
        access(1'b0, SIZE_HALF, 1'b0, 10'h011, 32'h0, 1'b1, 32'h0);
        access(1'b0, SIZE_RSVD, 1'b0, 10'h010, 32'h0, 1'b1, 32'h0);
        // Misaligned word store must not write
        access(1'b1, SIZE_WORD, 1'b0, 10'h014, 32'h11223344, 1'b0, 32'h0);
        access(1'b1, SIZE_WORD, 1'b0, 10'h016, 32'h12345678, 1'b1, 32'h0);
        access(1'b0, SIZE_WORD, 1'b0, 10'h014, 32'h0, 1'b0, 32'h11223344);
        // Half store into upper lanes
        access(1'b1, SIZE_WORD, 1'b0, 10'h018, 32'h00000000, 1'b0, 32'h0);
        access(1'b1, SIZE_HALF, 1'b0, 10'h01A, 32'h0000BEEF, 1'b0, 32'h0);
        access(1'b0, SIZE_HALF, 1'b0, 10'h01A, 32'h0, 1'b0, 32'hFFFFBEEF);
        access(1'b0, SIZE_WORD, 1'b0, 10'h018, 32'h0, 1'b0, 32'hBEEF0000);
        // Out of range (word index 64 with 64 words)
        access(1'b0, SIZE_WORD, 1'b0, 10'h100, 32'h0, 1'b1, 32'h0);
        idle(3);

        // Store during reset is dropped and produces no response
        rst   = 1'b1;
        req   = 1'b1;
        we    = 1'b1;
        size  = SIZE_WORD;
        addr  = 10'h014;
        wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 1'b0;
        we  = 1'b0;
        last_rdata = 32'h0;
        check("rst_rdata", rdata, 32'h0);
        idle(1);
        access(1'b0, SIZE_WORD, 1'b0, 10'h014, 32'h0, 1'b0, 32'h11223344);

        // Back-to-back stream of 8 stores then 8 loads
        for (int i = 0; i < 8; i++) begin
            access(1'b1, SIZE_WORD, 1'b0, 10'(32'h020 + 4 * i), 32'hA5000000 | i, 1'b0, 32'h0);
        end
        for (int i = 0; i < 8; i++) begin
            access(1'b0, SIZE_WORD, 1'b0, 10'(32'h020 + 4 * i), 32'h0, 1'b0, 32'hA5000000 | i);
        end
        idle(1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
        end
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
